branch_resolve_unit: RTL and testbench

- EX-stage branch resolution. Carries each ID-stage branch prediction and its two candidate PCs through an ID/EX register, then compares the prediction with the actual outcome in EX.
- On a mispredict it redirects fetch and flushes the younger stages.
- Produces the EX-side strobes (BranchInstructExists_EX, BranchDecision_EX passthrough) that train the downstream pattern-history predictor.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/branch_resolve_unit.sv | 118 +++++++++++
 tb/tb_branch_resolve_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution slice: FSM encoding,
// default PC width and the canonical ID/EX branch bundle layout.
package branch_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_e;

    localparam int DEFAULT_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 pred;
        logic [DEFAULT_W-1:0] target;
        logic [DEFAULT_W-1:0] pc4;
    } branch_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers the ID prediction, detects mispredicts,
// redirects fetch, holds Flush for FLUSH_CYCLES and keeps branch statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int W            = DEFAULT_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Stall_ID,
    input  logic             BranchInstructExists_ID,
    input  logic             Prediction_ID,
    input  logic [W-1:0]     BranchTarget_ID,
    input  logic [W-1:0]     PCPlus4_ID,
    input  logic             BranchOutcome_EX,
    output logic             BranchInstructExists_EX,
    output logic             BranchDecision_EX,
    output logic             Mispredict,
    output logic [W-1:0]     RedirectPC,
    output logic             Flush,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic         valid;
        logic         pred;
        logic [W-1:0] target;
        logic [W-1:0] pc4;
    } idex_t;

    idex_t      idex_q;
    idex_t      idex_d;
    bru_state_e state_q;
    bru_state_e state_d;
    logic [2:0] fc_q;
    logic [2:0] fc_d;
    logic       mispredict;
    logic       flush;

    assign mispredict = idex_q.valid & (BranchOutcome_EX != idex_q.pred);

    // The mispredict cycle itself is the first flush cycle; RECOVER covers the rest.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                flush = mispredict;
                if (mispredict && (FLUSH_CYCLES > 1)) begin
                    state_d = RECOVER;
                    fc_d    = FC_INIT;
                end
            end
            RECOVER: begin
                flush = 1'b1;
                fc_d  = fc_q - 3'd1;
                if (fc_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                fc_d    = 3'd0;
            end
        endcase
    end

    // Squashing takes priority over stalling; both insert a cleared bubble.
    always_comb begin
        idex_d = '0;
        if (!flush && !Stall_ID) begin
            idex_d.valid  = BranchInstructExists_ID;
            idex_d.pred   = Prediction_ID;
            idex_d.target = BranchTarget_ID;
            idex_d.pc4    = PCPlus4_ID;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            idex_q  <= '0;
            state_q <= RUN;
            fc_q    <= 3'd0;
        end else begin
            idex_q  <= idex_d;
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    assign BranchInstructExists_EX = idex_q.valid;
    assign BranchDecision_EX       = idex_q.valid & BranchOutcome_EX;
    assign Mispredict              = mispredict;
    assign Flush                   = flush;
    assign RedirectPC              = mispredict ? (BranchOutcome_EX ? idex_q.target : idex_q.pc4)
                                                : '0;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (idex_q.valid),
        .count (BranchCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (mispredict),
        .count (MispredictCount)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: three configurations share one
// stimulus stream; each scenario task checks the instance it targets.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        exists;
        logic        dec;
        logic        misp;
        logic        flush;
        logic [31:0] redirect;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        br;
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] pc4;
        logic        outcome;
    } stim_t;

    logic        Clock;
    logic        Reset;
    logic        Stall_ID;
    logic        br_id;
    logic        pred_id;
    logic [31:0] tgt_id;
    logic [31:0] pc4_id;
    logic        outcome_ex;

    logic        m_exists, m_dec, m_misp, m_flush;
    logic [31:0] m_redirect;
    logic [15:0] m_bc, m_mc;
    logic        s_exists, s_dec, s_misp, s_flush;
    logic [31:0] s_redirect;
    logic [3:0]  s_bc, s_mc;
    logic        o_exists, o_dec, o_misp, o_flush;
    logic [31:0] o_redirect;
    logic [15:0] o_bc, o_mc;

    exp_t obs_main, obs_sat, obs_one;
    exp_t sb[$];
    stim_t stim_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // Default configuration: FLUSH_CYCLES = 2, 16-bit counters.
    branch_resolve_unit #(.W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut_main (
        .Clock(Clock), .Reset(Reset), .Stall_ID(Stall_ID),
        .BranchInstructExists_ID(br_id), .Prediction_ID(pred_id),
        .BranchTarget_ID(tgt_id), .PCPlus4_ID(pc4_id), .BranchOutcome_EX(outcome_ex),
        .BranchInstructExists_EX(m_exists), .BranchDecision_EX(m_dec),
        .Mispredict(m_misp), .RedirectPC(m_redirect), .Flush(m_flush),
        .BranchCount(m_bc), .MispredictCount(m_mc)
    );

    // Narrow counters and a long recovery window.
    branch_resolve_unit #(.W(32), .FLUSH_CYCLES(4), .CNT_W(4)) dut_sat (
        .Clock(Clock), .Reset(Reset), .Stall_ID(Stall_ID),
        .BranchInstructExists_ID(br_id), .Prediction_ID(pred_id),
        .BranchTarget_ID(tgt_id), .PCPlus4_ID(pc4_id), .BranchOutcome_EX(outcome_ex),
        .BranchInstructExists_EX(s_exists), .BranchDecision_EX(s_dec),
        .Mispredict(s_misp), .RedirectPC(s_redirect), .Flush(s_flush),
        .BranchCount(s_bc), .MispredictCount(s_mc)
    );

    // Single-cycle flush configuration.
    branch_resolve_unit #(.W(32), .FLUSH_CYCLES(1), .CNT_W(16)) dut_one (
        .Clock(Clock), .Reset(Reset), .Stall_ID(Stall_ID),
        .BranchInstructExists_ID(br_id), .Prediction_ID(pred_id),
        .BranchTarget_ID(tgt_id), .PCPlus4_ID(pc4_id), .BranchOutcome_EX(outcome_ex),
        .BranchInstructExists_EX(o_exists), .BranchDecision_EX(o_dec),
        .Mispredict(o_misp), .RedirectPC(o_redirect), .Flush(o_flush),
        .BranchCount(o_bc), .MispredictCount(o_mc)
    );

    assign obs_main = {m_exists, m_dec, m_misp, m_flush, m_redirect, m_bc, m_mc};
    assign obs_sat  = {s_exists, s_dec, s_misp, s_flush, s_redirect, 12'd0, s_bc, 12'd0, s_mc};
    assign obs_one  = {o_exists, o_dec, o_misp, o_flush, o_redirect, o_bc, o_mc};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic stim_t st(int rst, int stall, int br, int pred, int tgt, int pc4, int out);
        stim_t s;
        s.rst     = rst[0];
        s.stall   = stall[0];
        s.br      = br[0];
        s.pred    = pred[0];
        s.tgt     = 32'(tgt);
        s.pc4     = 32'(pc4);
        s.outcome = out[0];
        return s;
    endfunction

    function automatic exp_t ex(int e, int d, int m, int f, int r, int bc, int mc);
        exp_t x;
        x.exists   = e[0];
        x.dec      = d[0];
        x.misp     = m[0];
        x.flush    = f[0];
        x.redirect = 32'(r);
        x.bc       = 16'(bc);
        x.mc       = 16'(mc);
        return x;
    endfunction

    task automatic applyStimulus(input stim_t s);
        Reset      = s.rst;
        Stall_ID   = s.stall;
        br_id      = s.br;
        pred_id    = s.pred;
        tgt_id     = s.tgt;
        pc4_id     = s.pc4;
        outcome_ex = s.outcome;
    endtask

    task automatic next_cycle;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        applyStimulus(st(1, 0, 0, 0, 0, 0, 0));
        next_cycle();
        next_cycle();
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset;
        exp_t e;
        do_reset();
        @(negedge Clock);
        sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); n_cmp++;
        if (obs_main !== e) begin n_fail++; $display("[TB] FAIL reset_main: got %h want %h", obs_main, e); end
        e = sb.pop_front(); n_cmp++;
        if (obs_sat !== e) begin n_fail++; $display("[TB] FAIL reset_sat: got %h want %h", obs_sat, e); end
        e = sb.pop_front(); n_cmp++;
        if (obs_one !== e) begin n_fail++; $display("[TB] FAIL reset_one: got %h want %h", obs_one, e); end
        next_cycle();
    endtask

    task automatic test_correct_taken;
        stim_t s;
        exp_t e;
        int cyc = 0;
        do_reset();
        stim_q.push_back(st(0, 0, 1, 1, 32'h100, 32'h44, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 1));            sb.push_back(ex(1, 1, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 1, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge Clock);
            e = sb.pop_front(); n_cmp++;
            if (obs_main !== e) begin n_fail++; $display("[TB] FAIL correct_taken cyc %0d: got %h want %h", cyc, obs_main, e); end
            next_cycle();
            cyc++;
        end
    endtask

    task automatic test_mispredict;
        stim_t s;
        exp_t e;
        int cyc = 0;
        do_reset();
        stim_q.push_back(st(0, 0, 1, 1, 32'h100, 32'h44, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 1, 0, 32'h200, 32'h48, 0)); sb.push_back(ex(1, 0, 1, 1, 32'h44, 0, 0));
        stim_q.push_back(st(0, 0, 1, 1, 32'h300, 32'h4c, 1)); sb.push_back(ex(0, 0, 0, 1, 0, 1, 1));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 1, 1));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 1, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge Clock);
            e = sb.pop_front(); n_cmp++;
            if (obs_main !== e) begin n_fail++; $display("[TB] FAIL mispredict cyc %0d: got %h want %h", cyc, obs_main, e); end
            next_cycle();
            cyc++;
        end
    endtask

    task automatic test_stall;
        stim_t s;
        exp_t e;
        int cyc = 0;
        do_reset();
        stim_q.push_back(st(0, 1, 1, 0, 32'h300, 32'h50, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 1, 1, 0, 32'h300, 32'h50, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 1, 0, 32'h300, 32'h50, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(1, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 1, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 1, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge Clock);
            e = sb.pop_front(); n_cmp++;
            if (obs_main !== e) begin n_fail++; $display("[TB] FAIL stall cyc %0d: got %h want %h", cyc, obs_main, e); end
            next_cycle();
            cyc++;
        end
    endtask

    // A mispredicting branch enters ID every 5 cycles, clear of both flush windows.
    task automatic test_saturation;
        exp_t e;
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            applyStimulus(st(0, 0, ((i % 5 == 0) && (i < 100)) ? 1 : 0, 1, 32'h800, 32'h80, 0));
            @(negedge Clock);
            if (i == 78 || i == 100) begin
                sb.push_back(ex(0, 0, 0, 0, 0, (i == 78) ? 16 : 20, (i == 78) ? 16 : 20));
                sb.push_back(ex(0, 0, 0, 0, 0, 15, 15));
                e = sb.pop_front(); n_cmp++;
                if ({obs_main.bc, obs_main.mc} !== {e.bc, e.mc}) begin
                    n_fail++;
                    $display("[TB] FAIL sat_main i=%0d: got %0d/%0d want %0d/%0d", i, obs_main.bc, obs_main.mc, e.bc, e.mc);
                end
                e = sb.pop_front(); n_cmp++;
                if ({obs_sat.bc, obs_sat.mc} !== {e.bc, e.mc}) begin
                    n_fail++;
                    $display("[TB] FAIL sat_narrow i=%0d: got %0d/%0d want %0d/%0d", i, obs_sat.bc, obs_sat.mc, e.bc, e.mc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_recover;
        stim_t s;
        exp_t e;
        int cyc = 0;
        do_reset();
        stim_q.push_back(st(0, 0, 1, 0, 32'h500, 32'h58, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 1));            sb.push_back(ex(1, 1, 1, 1, 32'h500, 0, 0));
        stim_q.push_back(st(1, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 1, 0, 1, 1));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge Clock);
            e = sb.pop_front(); n_cmp++;
            if (obs_sat !== e) begin n_fail++; $display("[TB] FAIL reset_mid_recover cyc %0d: got %h want %h", cyc, obs_sat, e); end
            next_cycle();
            cyc++;
        end
    endtask

    task automatic test_flush_one;
        stim_t s;
        exp_t e;
        int cyc = 0;
        do_reset();
        stim_q.push_back(st(0, 0, 1, 1, 32'h600, 32'h60, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(1, 0, 1, 1, 32'h60, 0, 0));
        stim_q.push_back(st(0, 0, 1, 0, 32'h700, 32'h64, 0)); sb.push_back(ex(0, 0, 0, 0, 0, 1, 1));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 1));            sb.push_back(ex(1, 1, 1, 1, 32'h700, 1, 1));
        stim_q.push_back(st(0, 0, 0, 0, 0, 0, 0));            sb.push_back(ex(0, 0, 0, 0, 0, 2, 2));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge Clock);
            e = sb.pop_front(); n_cmp++;
            if (obs_one !== e) begin n_fail++; $display("[TB] FAIL flush_one cyc %0d: got %h want %h", cyc, obs_one, e); end
            next_cycle();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(st(1, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_correct_taken();
        test_mispredict();
        test_stall();
        test_saturation();
        test_reset_mid_recover();
        test_flush_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
